ej32_fetch: RTL and testbench

//  Bytecode prefetch/assembly stage directly upstream of the eJ32 decoder.
//  - Streams bytes from program memory into a small byte FIFO.
//  - Uses the opcode_t map to find each instruction's operand length.
//  - Hands the decoder one complete instruction (opcode + big-endian operand) per handshake.
//  - Flushes and restarts on a branch redirect from the execute stage.

---
 rtl/ej32_fetch_if.sv | 53 +++++
 rtl/ej32_fetch.sv | 254 +++++++++++++++++++++++++
 tb/tb_ej32_fetch.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ej32_fetch_if.sv
// -----------------------------------------------------------------------------
// ej32_fetch_if
//   Bus bundle between the eJ32 fetch stage, its program memory, the execute
//   stage (redirects) and the decoder (instruction bundles).
//
//   Signals
//     mem_rd     fetch -> mem     byte read request this cycle
//     mem_a      fetch -> mem     17-bit byte address of the request
//     mem_d      mem   -> fetch   read data, valid exactly one cycle after mem_rd
//     jmp_en     exec  -> fetch   one-cycle redirect strobe
//     jmp_a      exec  -> fetch   redirect target address
//     instr_vld  fetch -> dec     bundle valid
//     instr_rdy  dec   -> fetch   decoder accepts bundle
//     instr_op   fetch -> dec     opcode byte
//     instr_opd  fetch -> dec     big-endian operand, zero-extended
//     instr_len  fetch -> dec     operand byte count (0, 1, 2 or 4)
//     instr_pc   fetch -> dec     address of the opcode byte
//     instr_ill  fetch -> dec     opcode not handled by the fetch stage
//
//   Modports
//     master : the fetch stage
//     slave  : everything around it (memory, execute, decoder)
// -----------------------------------------------------------------------------
interface ej32_fetch_if;
  logic        mem_rd;
  logic [16:0] mem_a;
  logic [7:0]  mem_d;
  logic        jmp_en;
  logic [16:0] jmp_a;
  logic        instr_vld;
  logic        instr_rdy;
  logic [7:0]  instr_op;
  logic [31:0] instr_opd;
  logic [2:0]  instr_len;
  logic [16:0] instr_pc;
  logic        instr_ill;

  modport master (
    output mem_rd, mem_a,
    input  mem_d,
    input  jmp_en, jmp_a,
    output instr_vld, instr_op, instr_opd, instr_len, instr_pc, instr_ill,
    input  instr_rdy
  );

  modport slave (
    input  mem_rd, mem_a,
    output mem_d,
    output jmp_en, jmp_a,
    input  instr_vld, instr_op, instr_opd, instr_len, instr_pc, instr_ill,
    output instr_rdy
  );
endinterface

// File: rtl/ej32_fetch.sv
// -----------------------------------------------------------------------------
// ej32_fetch
//   Bytecode prefetch / instruction assembly stage in front of the eJ32
//   decoder. Bytes stream from program memory into a small circular byte FIFO;
//   the head opcode is looked up to find its operand length, and once the
//   whole instruction is buffered it is handed to the decoder as a single
//   bundle (opcode + big-endian operand). A redirect from execute flushes the
//   FIFO and restarts fetching at the target.
//
//   Parameters
//     DEPTH     byte FIFO entries (power of 2, >= 5)
//     RESET_PC  first fetch address after reset
//
//   Ports
//     clk       clock, rising edge
//     rst_n     asynchronous active-low reset
//     bus       ej32_fetch_if.master (memory, redirect and decoder signals)
// -----------------------------------------------------------------------------
module ej32_fetch #(
  parameter int          DEPTH    = 8,
  parameter logic [16:0] RESET_PC = 17'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  ej32_fetch_if.master    bus
);

  localparam int PW = $clog2(DEPTH);   // FIFO pointer width
  localparam int CW = PW + 1;          // FIFO occupancy width (0..DEPTH)

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Opcodes with operands or special handling (JVM numbering plus the eJ32
  // extensions donext/ldi).
  localparam logic [7:0] OP_BIPUSH     = 8'h10;
  localparam logic [7:0] OP_SIPUSH     = 8'h11;
  localparam logic [7:0] OP_LDC        = 8'h12;
  localparam logic [7:0] OP_LDC_W      = 8'h13;
  localparam logic [7:0] OP_LDC2_W     = 8'h14;
  localparam logic [7:0] OP_ILOAD      = 8'h15;
  localparam logic [7:0] OP_ALOAD      = 8'h19;
  localparam logic [7:0] OP_ISTORE     = 8'h36;
  localparam logic [7:0] OP_ASTORE     = 8'h3A;
  localparam logic [7:0] OP_IINC       = 8'h84;
  localparam logic [7:0] OP_IFEQ       = 8'h99;
  localparam logic [7:0] OP_JSR        = 8'hA8;
  localparam logic [7:0] OP_RET        = 8'hA9;
  localparam logic [7:0] OP_TABLESW    = 8'hAA;
  localparam logic [7:0] OP_LOOKUPSW   = 8'hAB;
  localparam logic [7:0] OP_GETSTATIC  = 8'hB2;
  localparam logic [7:0] OP_INVOKESTAT = 8'hB8;
  localparam logic [7:0] OP_INVOKEINTF = 8'hB9;
  localparam logic [7:0] OP_INVOKEDYN  = 8'hBA;
  localparam logic [7:0] OP_JNEW       = 8'hBB;
  localparam logic [7:0] OP_NEWARRAY   = 8'hBC;
  localparam logic [7:0] OP_ANEWARRAY  = 8'hBD;
  localparam logic [7:0] OP_CHECKCAST  = 8'hC0;
  localparam logic [7:0] OP_INSTANCEOF = 8'hC1;
  localparam logic [7:0] OP_WIDE       = 8'hC4;
  localparam logic [7:0] OP_MULTIANEW  = 8'hC5;
  localparam logic [7:0] OP_IFNULL     = 8'hC6;
  localparam logic [7:0] OP_IFNONNULL  = 8'hC7;
  localparam logic [7:0] OP_GOTO_W     = 8'hC8;
  localparam logic [7:0] OP_JSR_W      = 8'hC9;
  localparam logic [7:0] OP_DONEXT     = 8'hCA;
  localparam logic [7:0] OP_LDI        = 8'hCB;

  // Operand byte count of an opcode; unsupported opcodes report 0.
  function automatic logic [2:0] op_len(input logic [7:0] op);
    logic [2:0] len;
    len = 3'd0;
    if (op inside {OP_BIPUSH, OP_LDC, [OP_ILOAD:OP_ALOAD], [OP_ISTORE:OP_ASTORE],
                   OP_RET, OP_NEWARRAY})
      len = 3'd1;
    else if (op inside {OP_SIPUSH, OP_LDC_W, OP_LDC2_W, OP_IINC, [OP_IFEQ:OP_JSR],
                        [OP_GETSTATIC:OP_INVOKESTAT], OP_JNEW, OP_ANEWARRAY,
                        OP_CHECKCAST, OP_INSTANCEOF, OP_IFNULL, OP_IFNONNULL,
                        OP_DONEXT})
      len = 3'd2;
    else if (op inside {OP_GOTO_W, OP_JSR_W, OP_INVOKEINTF, OP_INVOKEDYN, OP_LDI})
      len = 3'd4;
    return len;
  endfunction

  // Variable-length encodings this stage cannot frame; only the opcode byte
  // is consumed and the decoder is told via instr_ill.
  function automatic logic op_ill(input logic [7:0] op);
    return op inside {OP_TABLESW, OP_LOOKUPSW, OP_WIDE, OP_MULTIANEW};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_q [DEPTH];
  ptr_t        rd_ptr_q,   rd_ptr_d;
  ptr_t        wr_ptr_q,   wr_ptr_d;
  cnt_t        count_q,    count_d;
  logic        inflight_q, inflight_d;
  logic        run_q,      run_d;
  logic [16:0] fa_q,       fa_d;       // next fetch address
  logic [16:0] head_pc_q,  head_pc_d;  // address of the FIFO head byte
  logic        vld_q,      vld_d;
  logic [7:0]  op_q,       op_d;
  logic [31:0] opd_q,      opd_d;
  logic [2:0]  len_q,      len_d;
  logic [16:0] pc_q,       pc_d;
  logic        ill_q,      ill_d;

  // ---------------------------------------------------------------------------
  // Head-of-FIFO decode
  // ---------------------------------------------------------------------------
  logic [7:0]  head_op;
  logic [2:0]  head_len;
  logic        head_ill;
  logic [7:0]  opd_byte [4];
  logic [31:0] head_opd;
  cnt_t        need;

  assign head_op  = fifo_q[rd_ptr_q];
  assign head_len = op_len(head_op);
  assign head_ill = op_ill(head_op);
  assign need     = cnt_t'(head_len) + cnt_t'(1);

  // Operand bytes follow the opcode; the pointer arithmetic wraps modulo
  // DEPTH so an operand split across the end of the buffer is still in order.
  for (genvar gi = 0; gi < 4; gi++) begin : g_opd
    ptr_t idx;
    assign idx          = rd_ptr_q + ptr_t'(gi + 1);
    assign opd_byte[gi] = fifo_q[idx];
  end

  always_comb begin
    head_opd = 32'h0;
    case (head_len)
      3'd1:    head_opd = {24'h0, opd_byte[0]};
      3'd2:    head_opd = {16'h0, opd_byte[0], opd_byte[1]};
      3'd4:    head_opd = {opd_byte[0], opd_byte[1], opd_byte[2], opd_byte[3]};
      default: head_opd = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic push;
  logic load;
  logic mem_rd;

  always_comb begin
    // A byte returning during a redirect belongs to the old stream.
    push = inflight_q & ~bus.jmp_en;
    load = ~bus.jmp_en & (count_q >= need) & (~vld_q | bus.instr_rdy);
    // Bytes already in flight have a slot reserved, so the FIFO never overflows.
    // run_q keeps reads off while reset is asserted.
    mem_rd = run_q & ~bus.jmp_en & ((count_q + cnt_t'(inflight_q)) < cnt_t'(DEPTH));

    run_d      = 1'b1;
    inflight_d = mem_rd;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fa_d       = fa_q;
    head_pc_d  = head_pc_q;
    vld_d      = vld_q;
    op_d       = op_q;
    opd_d      = opd_q;
    len_d      = len_q;
    pc_d       = pc_q;
    ill_d      = ill_q;

    if (bus.jmp_en) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      fa_d      = bus.jmp_a;
      head_pc_d = bus.jmp_a;
      vld_d     = 1'b0;
      pc_d      = bus.jmp_a;
    end else begin
      if (mem_rd)
        fa_d = fa_q + 17'd1;
      if (push)
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - (load ? need : cnt_t'(0));
      if (load) begin
        rd_ptr_d  = rd_ptr_q + ptr_t'(need);
        head_pc_d = head_pc_q + 17'(need);
        vld_d     = 1'b1;
        op_d      = head_op;
        opd_d     = head_opd;
        len_d     = head_len;
        pc_d      = head_pc_q;
        ill_d     = head_ill;
      end else if (bus.instr_rdy) begin
        vld_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fa_q       <= RESET_PC;
      head_pc_q  <= RESET_PC;
      vld_q      <= 1'b0;
      op_q       <= 8'h0;
      opd_q      <= 32'h0;
      len_q      <= 3'd0;
      pc_q       <= RESET_PC;
      ill_q      <= 1'b0;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fa_q       <= fa_d;
      head_pc_q  <= head_pc_d;
      vld_q      <= vld_d;
      op_q       <= op_d;
      opd_q      <= opd_d;
      len_q      <= len_d;
      pc_q       <= pc_d;
      ill_q      <= ill_d;
    end
  end

  // Byte storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= bus.mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_a     = fa_q;
  assign bus.instr_vld = vld_q;
  assign bus.instr_op  = op_q;
  assign bus.instr_opd = opd_q;
  assign bus.instr_len = len_q;
  assign bus.instr_pc  = pc_q;
  assign bus.instr_ill = ill_q;

endmodule

// File: tb/tb_ej32_fetch.sv
`timescale 1ns/1ps
module tb_ej32_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ej32_fetch_if bus();

  ej32_fetch #(.DEPTH(8), .RESET_PC(17'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Program memory: data appears one cycle after the request.
  logic [7:0] pmem [0:131071];
  always @(posedge clk) bus.mem_d <= bus.mem_rd ? pmem[bus.mem_a] : 8'hEE;

  typedef struct {
    logic [16:0] pc;
    logic [7:0]  op;
    logic [31:0] opd;
    logic [2:0]  len;
    logic        ill;
  } bundle_t;

  typedef struct {
    logic [39:0] raw;    // instruction bytes, left-aligned
    int          nraw;
    bundle_t     exp;
  } vec_t;

  localparam int NV = 17;
  vec_t    vt [NV];
  bundle_t got [$];

  int n_vec = 0;
  int n_err = 0;

  // Every accepted bundle is logged.
  always @(negedge clk) begin
    if (rst_n && bus.instr_vld && bus.instr_rdy) begin
      bundle_t b;
      b.pc  = bus.instr_pc;
      b.op  = bus.instr_op;
      b.opd = bus.instr_opd;
      b.len = bus.instr_len;
      b.ill = bus.instr_ill;
      got.push_back(b);
      $display("bundle pc=%05h op=%02h opd=%08h len=%0d ill=%0b",
               b.pc, b.op, b.opd, b.len, b.ill);
    end
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string name, input bundle_t a, input bundle_t e);
    check({name, " pc"},  40'(a.pc),  40'(e.pc));
    check({name, " op"},  40'(a.op),  40'(e.op));
    check({name, " opd"}, 40'(a.opd), 40'(e.opd));
    check({name, " len"}, 40'(a.len), 40'(e.len));
    check({name, " ill"}, 40'(a.ill), 40'(e.ill));
  endtask

  task automatic wait_bundles(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (got.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d bundles seen, %0d required", got.size(), n);
    end
  endtask

  task automatic check_got(input int idx, input bundle_t e);
    if (idx < got.size()) check_bundle($sformatf("b%0d@%05h", idx, e.pc), got[idx], e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_rd"},    40'(bus.mem_rd),    40'(0));
    check({tag, " mem_a"},     40'(bus.mem_a),     40'(0));
    check({tag, " instr_vld"}, 40'(bus.instr_vld), 40'(0));
    check({tag, " instr_op"},  40'(bus.instr_op),  40'(0));
    check({tag, " instr_opd"}, 40'(bus.instr_opd), 40'(0));
    check({tag, " instr_len"}, 40'(bus.instr_len), 40'(0));
    check({tag, " instr_pc"},  40'(bus.instr_pc),  40'(0));
    check({tag, " instr_ill"}, 40'(bus.instr_ill), 40'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          rd_cnt;
    logic        seen_vld;
    logic        changed;
    bundle_t     first;
    bundle_t     e;
    logic        prev_rd;
    logic        found;
    logic [16:0] jmp_pc;
    int          nbefore;

    rst_n         = 1'b1;
    bus.instr_rdy = 1'b0;
    bus.jmp_en    = 1'b0;
    bus.jmp_a     = 17'h0;

    // Main program at 0: pc, raw bytes, count, expected bundle.
    vt[0]  = '{40'h1005000000, 2, '{17'h00000, 8'h10, 32'h00000005, 3'd1, 1'b0}};
    vt[1]  = '{40'h1112340000, 3, '{17'h00002, 8'h11, 32'h00001234, 3'd2, 1'b0}};
    vt[2]  = '{40'h6000000000, 1, '{17'h00005, 8'h60, 32'h00000000, 3'd0, 1'b0}};
    vt[3]  = '{40'hC800000100, 5, '{17'h00006, 8'hC8, 32'h00000100, 3'd4, 1'b0}};
    vt[4]  = '{40'hAA00000000, 1, '{17'h0000B, 8'hAA, 32'h00000000, 3'd0, 1'b1}};
    vt[5]  = '{40'h1507000000, 2, '{17'h0000C, 8'h15, 32'h00000007, 3'd1, 1'b0}};
    vt[6]  = '{40'h8401FF0000, 3, '{17'h0000E, 8'h84, 32'h000001FF, 3'd2, 1'b0}};
    vt[7]  = '{40'hB901020304, 5, '{17'h00011, 8'hB9, 32'h01020304, 3'd4, 1'b0}};
    vt[8]  = '{40'h3A09000000, 2, '{17'h00016, 8'h3A, 32'h00000009, 3'd1, 1'b0}};
    vt[9]  = '{40'hC400000000, 1, '{17'h00018, 8'hC4, 32'h00000000, 3'd0, 1'b1}};
    vt[10] = '{40'h99FFF00000, 3, '{17'h00019, 8'h99, 32'h0000FFF0, 3'd2, 1'b0}};
    vt[11] = '{40'hC9DEADBEEF, 5, '{17'h0001C, 8'hC9, 32'hDEADBEEF, 3'd4, 1'b0}};
    vt[12] = '{40'hBC0A000000, 2, '{17'h00021, 8'hBC, 32'h0000000A, 3'd1, 1'b0}};
    vt[13] = '{40'hA903000000, 2, '{17'h00023, 8'hA9, 32'h00000003, 3'd1, 1'b0}};
    vt[14] = '{40'hC100070000, 3, '{17'h00025, 8'hC1, 32'h00000007, 3'd2, 1'b0}};
    vt[15] = '{40'hAB00000000, 1, '{17'h00028, 8'hAB, 32'h00000000, 3'd0, 1'b1}};
    vt[16] = '{40'h0000000000, 1, '{17'h00029, 8'h00, 32'h00000000, 3'd0, 1'b0}};

    for (int a = 0; a < 131072; a++) pmem[a] = 8'h00;
    for (int i = 0; i < NV; i++)
      for (int k = 0; k < vt[i].nraw; k++)
        pmem[vt[i].exp.pc + 17'(k)] = vt[i].raw[39 - 8*k -: 8];
    // bipush 1..8 at 0x30, then ldc 77 / iadd at 0x40
    for (int k = 0; k < 8; k++) begin
      pmem[17'h30 + 17'(2*k)]     = 8'h10;
      pmem[17'h30 + 17'(2*k + 1)] = 8'(k + 1);
    end
    pmem[17'h40] = 8'h12; pmem[17'h41] = 8'h77; pmem[17'h42] = 8'h60;
    pmem[17'h50] = 8'h10; pmem[17'h51] = 8'h99;
    pmem[17'h1FFFE] = 8'h11; pmem[17'h1FFFF] = 8'hAB;

    // ---- reset values ----
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // ---- backpressure: decoder stalled ----
    rd_cnt = 0; seen_vld = 1'b0; changed = 1'b0;
    first = '{17'h0, 8'h0, 32'h0, 3'd0, 1'b0};
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.mem_rd) rd_cnt++;
      if (bus.instr_vld) begin
        if (!seen_vld) begin
          seen_vld  = 1'b1;
          first.pc  = bus.instr_pc;
          first.op  = bus.instr_op;
          first.opd = bus.instr_opd;
          first.len = bus.instr_len;
          first.ill = bus.instr_ill;
        end else if (bus.instr_pc !== first.pc || bus.instr_op !== first.op ||
                     bus.instr_opd !== first.opd || bus.instr_len !== first.len)
          changed = 1'b1;
      end else if (seen_vld) begin
        changed = 1'b1;
      end
    end
    // 8 buffered bytes plus the 2 already moved into the output register
    check("stall reads issued", 40'(rd_cnt), 40'(10));
    check("stall vld", 40'(bus.instr_vld), 40'(1));
    check("stall bundle stable", 40'(changed), 40'(0));
    check_bundle("stall", first, vt[0].exp);
    check("stall no handshake", 40'(got.size()), 40'(0));

    // ---- release: every table vector in order, none lost ----
    got.delete();
    bus.instr_rdy = 1'b1;
    wait_bundles(NV, 300);
    for (int i = 0; i < NV; i++) check_got(i, vt[i].exp);

    // ---- back-to-back redirects, target 1FFFE, fetch address wraps ----
    pmem[0] = 8'hCD;
    @(posedge clk); #1;
    bus.jmp_en = 1'b1; bus.jmp_a = 17'h00050;
    @(posedge clk); #1;
    bus.jmp_a = 17'h1FFFE;
    @(posedge clk); #1;
    bus.jmp_en = 1'b0;
    got.delete();
    wait_bundles(2, 50);
    e = '{17'h1FFFE, 8'h11, 32'h0000ABCD, 3'd2, 1'b0}; check_got(0, e);
    e = '{17'h00001, 8'h05, 32'h00000000, 3'd0, 1'b0}; check_got(1, e);

    // ---- redirect with a byte in flight and a handshake in the same cycle ----
    @(posedge clk); #1;
    bus.jmp_en = 1'b1; bus.jmp_a = 17'h00030;
    @(posedge clk); #1;
    bus.jmp_en = 1'b0;
    got.delete();
    wait_bundles(2, 50);
    prev_rd = 1'b0; found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.instr_vld && prev_rd) found = 1'b1;
      else prev_rd = bus.mem_rd;
    end
    check("jmp setup vld&inflight", 40'(found), 40'(1));
    jmp_pc  = bus.instr_pc;
    nbefore = got.size();
    bus.jmp_en = 1'b1; bus.jmp_a = 17'h00040;
    #1;
    check("jmp cycle mem_rd", 40'(bus.mem_rd), 40'(0));
    @(posedge clk); #1;
    bus.jmp_en = 1'b0;
    check("jmp handshake counted", 40'(got.size()), 40'(nbefore + 1));
    if (got.size() > 0) check("jmp handshake pc", 40'(got[got.size()-1].pc), 40'(jmp_pc));
    check("after jmp vld", 40'(bus.instr_vld), 40'(0));
    check("after jmp pc", 40'(bus.instr_pc), 40'(17'h00040));
    got.delete();
    wait_bundles(2, 50);
    e = '{17'h00040, 8'h12, 32'h00000077, 3'd1, 1'b0}; check_got(0, e);
    e = '{17'h00042, 8'h60, 32'h00000000, 3'd0, 1'b0}; check_got(1, e);

    // ---- reset in the middle of streaming ----
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pmem[0] = 8'h10;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    got.delete();
    wait_bundles(2, 50);
    check_got(0, vt[0].exp);
    check_got(1, vt[1].exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
